// File: rtl/tft_rx_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tft_rx_monitor                                                           |
// | Recovers the active pixel stream and x/y position from a parallel-RGB    |
// | TFT link using data-enable only, and checks line and frame geometry.     |
// | Optional: TFT_RX_CHECKSUM_EN builds the per-frame pixel checksum.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tft_rx_monitor #(
    parameter int X_RES      = 480,
    parameter int Y_RES      = 272,
    parameter int X_NUM_BITS = 10,
    parameter int Y_NUM_BITS = 9,
    parameter int VBLANK_GAP = 256
) (
    input  logic                  tft_clk,
    input  logic                  rstb,
    input  logic                  tft_data_ena,
    input  logic [7:0]            tft_red,
    input  logic [7:0]            tft_green,
    input  logic [7:0]            tft_blue,
    output logic                  pix_valid,
    output logic [X_NUM_BITS-1:0] pix_x,
    output logic [Y_NUM_BITS-1:0] pix_y,
    output logic [2:0]            pix_r,
    output logic [2:0]            pix_g,
    output logic [2:0]            pix_b,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  line_err,
    output logic                  frame_err,
    output logic                  locked,
    output logic [15:0]           frame_sum
);
    localparam int                    GAP_W      = $clog2(VBLANK_GAP + 1);
    localparam logic [GAP_W-1:0]      C_GAP_LAST = GAP_W'(VBLANK_GAP - 1);
    localparam logic [GAP_W-1:0]      C_GAP_MAX  = GAP_W'(VBLANK_GAP);
    localparam logic [GAP_W-1:0]      C_GAP_ONE  = GAP_W'(1);
    localparam logic [X_NUM_BITS-1:0] C_X_RES    = X_NUM_BITS'(X_RES);
    localparam logic [X_NUM_BITS-1:0] C_X_ONE    = X_NUM_BITS'(1);
    localparam logic [Y_NUM_BITS-1:0] C_Y_RES    = Y_NUM_BITS'(Y_RES);
    localparam logic [Y_NUM_BITS-1:0] C_Y_ONE    = Y_NUM_BITS'(1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_ena, r_ena_d;
    logic [2:0]            r_red, r_green, r_blue;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [X_NUM_BITS-1:0] r_x_cnt, w_x_nxt;
    logic [Y_NUM_BITS-1:0] r_y_cnt, w_y_nxt;
    logic                  r_frame_bad;
    logic                  w_gap_hit, w_fall;
    logic                  w_pix, w_first, w_line_err, w_frame_done, w_frame_err;
    logic                  w_unused;

    assign w_unused  = ^{tft_red[4:0], tft_green[4:0], tft_blue[4:0]};
    assign w_gap_hit = !r_ena && (r_gap_cnt == C_GAP_LAST);
    assign w_fall    = !r_ena && r_ena_d;

    // Input sampling stage; all decisions below act on these samples.
    always_ff @(posedge tft_clk or negedge rstb) begin
        if (!rstb) begin
            r_ena     <= 1'b0;
            r_ena_d   <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_ena   <= tft_data_ena;
            r_ena_d <= r_ena;
            r_red   <= tft_red[7:5];
            r_green <= tft_green[7:5];
            r_blue  <= tft_blue[7:5];
            if (r_ena)
                r_gap_cnt <= '0;
            else if (r_gap_cnt != C_GAP_MAX)
                r_gap_cnt <= r_gap_cnt + C_GAP_ONE;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x_cnt;
        w_y_nxt      = r_y_cnt;
        w_pix        = 1'b0;
        w_first      = 1'b0;
        w_line_err   = 1'b0;
        w_frame_done = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_gap_hit) begin
                    w_state_nxt = S_WAIT;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end
            S_WAIT: begin
                // Counters are already zero here, so this sample is pixel (0,0).
                if (r_ena) begin
                    w_pix       = 1'b1;
                    w_first     = 1'b1;
                    w_x_nxt     = C_X_ONE;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (r_ena) begin
                    w_pix = (r_x_cnt < C_X_RES) && (r_y_cnt < C_Y_RES);
                    if (!(&r_x_cnt))
                        w_x_nxt = r_x_cnt + C_X_ONE;
                end else if (w_fall) begin
                    w_x_nxt    = '0;
                    w_line_err = (r_x_cnt != C_X_RES);
                    if (!(&r_y_cnt))
                        w_y_nxt = r_y_cnt + C_Y_ONE;
                end else if (w_gap_hit) begin
                    w_frame_done = 1'b1;
                    w_frame_err  = (r_y_cnt != C_Y_RES);
                    w_state_nxt  = S_WAIT;
                    w_x_nxt      = '0;
                    w_y_nxt      = '0;
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    always_ff @(posedge tft_clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= S_SEARCH;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_frame_bad <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x_cnt     <= w_x_nxt;
            r_y_cnt     <= w_y_nxt;
            pix_valid   <= w_pix;
            frame_start <= w_first;
            frame_done  <= w_frame_done;
            line_err    <= w_line_err;
            frame_err   <= w_frame_err;
            if (w_pix) begin
                pix_x <= r_x_cnt;
                pix_y <= r_y_cnt;
                pix_r <= r_red;
                pix_g <= r_green;
                pix_b <= r_blue;
            end
            if (w_first)
                r_frame_bad <= 1'b0;
            else if (w_line_err)
                r_frame_bad <= 1'b1;
            // Any error drops lock at once; only a clean frame end restores it.
            if (w_line_err || w_frame_err)
                locked <= 1'b0;
            else if (w_frame_done && !r_frame_bad)
                locked <= 1'b1;
        end
    end

`ifdef TFT_RX_CHECKSUM_EN
    logic [15:0] r_acc;

    always_ff @(posedge tft_clk or negedge rstb) begin
        if (!rstb) begin
            r_acc     <= '0;
            frame_sum <= '0;
        end else if (w_frame_done) begin
            frame_sum <= r_acc;
            r_acc     <= '0;
        end else if (w_pix) begin
            r_acc <= r_acc + {7'd0, r_red, r_green, r_blue};
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tft_rx_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tft_rx_monitor                                                        |
// | Directed self-checking bench for tft_rx_monitor on a reduced geometry.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tft_rx_monitor;
    localparam int XR    = 16;
    localparam int YR    = 4;
    localparam int GAP   = 32;
    localparam int HB    = 6;
    localparam int LINE  = XR + HB;
    localparam int BLANK = 4 * LINE;

    logic        tft_clk = 1'b0;
    logic        rstb    = 1'b1;
    logic        ena     = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [2:0]  pix_r, pix_g, pix_b;
    logic        frame_start, frame_done, line_err, frame_err, locked;
    logic [15:0] frame_sum;

    tft_rx_monitor #(
        .X_RES(XR), .Y_RES(YR), .X_NUM_BITS(10), .Y_NUM_BITS(9), .VBLANK_GAP(GAP)
    ) dut (
        .tft_clk(tft_clk), .rstb(rstb), .tft_data_ena(ena),
        .tft_red(red), .tft_green(green), .tft_blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err),
        .locked(locked), .frame_sum(frame_sum)
    );

    always #5 tft_clk = ~tft_clk;

    int cyc = 0;
    always @(posedge tft_clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [27:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] m_acc = '0;
    int          last_hi_cyc = 0;
    int          exp_lerr_cyc = 0;
    logic        exp_ferr = 1'b0;
    int          n_fd = 0, n_lerr = 0, n_ferr = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge tft_clk) begin
        if (pix_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("px_unexpected", {31'd0, pix_valid}, 32'd0);
            end else begin
                check_eq("px_data", {4'd0, pix_x, pix_y, pix_r, pix_g, pix_b}, {4'd0, exp_q[0]});
                check_eq("px_latency", cyc, exp_cyc_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (pix_x == 10'd0 && pix_y == 9'd0)
                check_eq("px00_frame_start", {31'd0, frame_start}, 32'd1);
        end
        if (frame_start === 1'b1)
            check_eq("frame_start_xy", {12'd0, pix_valid, pix_x, pix_y}, {12'd0, 1'b1, 19'd0});
        if (line_err === 1'b1) begin
            n_lerr++;
            check_eq("line_err_time", cyc, exp_lerr_cyc);
            check_eq("line_err_lock", {31'd0, locked}, 32'd0);
        end
        if (frame_err === 1'b1 && frame_done !== 1'b1)
            check_eq("frame_err_with_done", {31'd0, frame_done}, 32'd1);
        if (frame_done === 1'b1) begin
            n_fd++;
            if (frame_err === 1'b1) n_ferr++;
            check_eq("frame_done_time", cyc, last_hi_cyc + GAP + 2);
            check_eq("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
`ifdef TFT_RX_CHECKSUM_EN
            check_eq("frame_sum", {16'd0, frame_sum}, {16'd0, m_acc});
`else
            check_eq("frame_sum", {16'd0, frame_sum}, 32'd0);
`endif
            m_acc = '0;
        end
    end

    task automatic drive_px(input bit hi, input int x, input int y, input bit pattern, input bit expect_px);
        logic [2:0] rr, gg, bb;
        @(posedge tft_clk);
        #1;
        ena = hi;
        if (hi) begin
            if (pattern) begin
                rr = 3'd7; gg = 3'd3; bb = 3'd0;
            end else begin
                rr = 3'(x); gg = 3'(y); bb = 3'(x + y);
            end
            red   = {rr, 5'($urandom)};
            green = {gg, 5'($urandom)};
            blue  = {bb, 5'($urandom)};
            last_hi_cyc = cyc;
            if (expect_px && x < XR && y < YR) begin
                exp_q.push_back({10'(x), 9'(y), rr, gg, bb});
                exp_cyc_q.push_back(cyc + 2);
                m_acc = m_acc + {7'd0, rr, gg, bb};
            end
        end else begin
            red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pix"}, {3'd0, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}, 32'd0);
        check_eq({tag, "_flags"}, {11'd0, frame_start, frame_done, line_err, frame_err, locked, frame_sum}, 32'd0);
    endtask

    task automatic run_frame(input int nlines, input int bad_line, input int bad_len, input bit pattern,
                             input int rst_line, input int e_fd, input int e_lerr, input int e_ferr,
                             input bit e_lock, input string tag);
        bit expect_px = 1'b1;
        int len;
        n_fd = 0; n_lerr = 0; n_ferr = 0;
        exp_ferr = (nlines != YR);
        for (int y = 0; y < nlines; y++) begin
            len = (y == bad_line) ? bad_len : XR;
            for (int x = 0; x < len; x++) begin
                if (y == rst_line && x == 5) begin
                    @(posedge tft_clk);
                    #3;
                    rstb = 1'b0;
                    exp_q.delete();
                    exp_cyc_q.delete();
                    m_acc = '0;
                    expect_px = 1'b0;
                    #1;
                    check_reset_outputs({tag, "_midreset"});
                    @(posedge tft_clk);
                    #1;
                    rstb = 1'b1;
                end
                drive_px(1'b1, x, y, pattern, expect_px);
            end
            if (len != XR) exp_lerr_cyc = last_hi_cyc + 3;
            for (int i = 0; i < HB; i++) drive_px(1'b0, 0, 0, pattern, 1'b0);
        end
        for (int i = 0; i < BLANK; i++) drive_px(1'b0, 0, 0, pattern, 1'b0);
        check_eq({tag, "_n_frame_done"}, n_fd, e_fd);
        check_eq({tag, "_n_line_err"}, n_lerr, e_lerr);
        check_eq({tag, "_n_frame_err"}, n_ferr, e_ferr);
        check_eq({tag, "_locked"}, {31'd0, locked}, {31'd0, e_lock});
        check_eq({tag, "_px_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #2 rstb = 1'b0;
        repeat (3) @(posedge tft_clk);
        #1;
        check_reset_outputs("reset");
        rstb = 1'b1;

        // Highs before any vertical gap must be ignored.
        for (int i = 0; i < 2; i++) drive_px(1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_px(1'b1, i, 0, 1'b0, 1'b0);
        for (int i = 0; i < GAP + 8; i++) drive_px(1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("locked_before_frame", {31'd0, locked}, 32'd0);

        //        lines   bad  len  pat  rst  fd lerr ferr lock tag
        run_frame(YR,     -1,  0,   0,   -1,  1, 0,   0,   1,   "clean1");
        run_frame(YR,     -1,  0,   0,   -1,  1, 0,   0,   1,   "clean2");
        run_frame(YR,      2,  XR-1,0,   -1,  1, 1,   0,   0,   "short_line");
        run_frame(YR,     -1,  0,   0,   -1,  1, 0,   0,   1,   "relock");
        run_frame(YR+1,   -1,  0,   0,   -1,  1, 0,   1,   0,   "extra_line");
        run_frame(YR,      1,  XR+2,0,   -1,  1, 1,   0,   0,   "long_line");
        run_frame(YR,     -1,  0,   1,   -1,  1, 0,   0,   1,   "checksum");
`ifdef TFT_RX_CHECKSUM_EN
        check_eq("frame_sum_472", {16'd0, frame_sum}, 32'd30208);
`else
        check_eq("frame_sum_472", {16'd0, frame_sum}, 32'd0);
`endif
        run_frame(YR,     -1,  0,   0,   2,   0, 0,   0,   0,   "midreset");
        run_frame(YR,     -1,  0,   0,   -1,  1, 0,   0,   1,   "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tft_rx_monitor.md
# tft_rx_monitor

Receiving end of the parallel-RGB TFT link: samples the data-enable and 8-bit colour buses on the pixel clock and recovers the active pixel stream. It reconstructs pixel x/y coordinates from the enable signal alone, detects frame boundaries and checks line and frame geometry. It sits on the loopback/verification path beside the panel driver and feeds capture and self-test logic.

## Interface

Parameters:
- X_RES, 480, expected active pixels per line
- Y_RES, 272, expected active lines per frame
- X_NUM_BITS, 10, width of pix_x and the internal x counter
- Y_NUM_BITS, 9, width of pix_y and the internal y counter
- VBLANK_GAP, 256, minimum run of consecutive enable-low cycles treated as vertical blanking; must exceed horizontal blanking (45)

Ports:
- tft_clk  in  1  pixel clock; all logic on its rising edge
- rstb  in  1  reset, asynchronous assert, active-low
- tft_data_ena  in  1  data enable from the link
- tft_red, tft_green, tft_blue  in  8 each  colour buses; only bits [7:5] are used
- pix_valid  out  1  registered; the pix_* fields hold an in-range active pixel
- pix_x  out  X_NUM_BITS  pixel column
- pix_y  out  Y_NUM_BITS  pixel row
- pix_r, pix_g, pix_b  out  3 each  bits [7:5] of the matching input bus
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- frame_done  out  1  one-cycle pulse at vertical blank detection
- line_err  out  1  one-cycle pulse when a line's enable run is not X_RES
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the line count is not Y_RES
- locked  out  1  level; geometry verified
- frame_sum  out  16  per-frame pixel checksum; see Configuration

## Operation

- **Reset values.** All outputs and counters are 0. The state machine is in SEARCH.
- **gap_cnt.** Counts consecutive enable-low samples. It saturates at VBLANK_GAP and clears on any enable-high sample.
- **x_cnt.** Counts enable-high samples within a line. It clears on the first low sample after a high run.
- **y_cnt.** Counts completed lines in the current frame.

State machine:
- **SEARCH.** Enable-high samples are ignored and pix_valid stays 0. When gap_cnt reaches VBLANK_GAP, go to WAIT.
- **WAIT.** On the first enable-high sample, go to ACTIVE with x_cnt=0 and y_cnt=0.
- **ACTIVE.**
  - Each enable-high sample produces a pixel at (x_cnt, y_cnt).
  - On an enable falling edge, y_cnt increments. line_err pulses if the run length is not X_RES.
  - When gap_cnt reaches VBLANK_GAP, frame_done pulses. frame_err pulses if y_cnt is not Y_RES. Then go to WAIT.

Pixel output:
- pix_valid is 1 only for pixels with x_cnt < X_RES and y_cnt < Y_RES.
- Over-long lines and extra lines still count toward the error checks but emit no pixels.
- x_cnt and y_cnt saturate at their all-ones value and do not wrap.

Lock:
- locked sets at frame_done when the frame just ended had no line_err and no frame_err.
- locked clears on the cycle any line_err or frame_err pulses.
- An error does not return the state machine to SEARCH.

Other boundary rules:
- If an enable run ends and the line is also the last of the frame, the line_err check fires on the falling edge. The frame_err check fires later, at the gap threshold.
- An asynchronous reset mid-frame returns the block to SEARCH. The partial frame is discarded.

## Timing

- Pixel latency: the enable and colour inputs are sampled at edge N, and pix_* are valid after edge N+1, so latency is 1 cycle.
- line_err is registered after edge F+1, where F is the edge that samples the first low enable.
- frame_done and frame_err assert in the same cycle, exactly VBLANK_GAP low samples after the last high sample.
- frame_start is coincident with the pix_valid for pixel (0,0).
- Throughput is one pixel per cycle, with no backpressure.

## Configuration

- **With TFT_RX_CHECKSUM_EN defined:**
  - An accumulator adds the 9-bit value {r[7:5], g[7:5], b[7:5]} for every pix_valid pixel, modulo 2^16.
  - frame_sum latches the accumulator at frame_done, and the accumulator then clears.
  - frame_sum holds its value until the next frame_done.
- **Without TFT_RX_CHECKSUM_EN:** frame_sum is constant 0 and no accumulator is built.

## Test plan

- **Lock and geometry.** Reset, then drive the driver timing: 480 enable-high plus 45 low per line, 272 lines, then 16 blank lines. Required: frame_done pulses every 151200 cycles, no line_err or frame_err, and locked rises at the end of the first complete frame after WAIT.
- **Coordinates.** In a locked frame, check that frame_start coincides with pix_x=0, pix_y=0. Check that the last pix_valid shows pix_x=479, pix_y=271 on the cycle after its sample.
- **Short line.** Make line 10 only 479 pixels long. Required: one line_err pulse one cycle after that run ends, and locked drops. The next clean frame re-asserts locked at its frame_done.
- **Extra line.** Drive a frame with 273 lines. Required: no pix_valid on line 272, and frame_err coincides with frame_done.
- **Mid-frame reset.** Assert rstb low during line 100. Required: all outputs read 0 immediately. After release, no pix_valid appears until a gap of 256 low cycles has been seen.
- **Checksum (TFT_RX_CHECKSUM_EN).** Send a full frame with r=7, g=3, b=0 on every pixel, giving a pixel value of 472. Required: frame_sum = 130560 × 472 mod 65536 = 20480 at frame_done. Without the macro, frame_sum = 0.
